exposure_timer_ctrl: RTL and testbench
======================================

Name: exposure_timer_ctrl

Overview:
- Programmable exposure-time controller for the pixel array's exposure/readout sequencer.
- Holds the user-selected exposure time, adjusted by Exp_increase/Exp_decrease buttons only while idle.
- On Init, times the exposure window while the sequencer holds Expose high, then issues the one-cycle Ovf5 pulse that ends exposure.
- Detects a sequencer that never starts, or aborts, exposure.

Parameters:
CNT_W, 5, width of exposure-time register and countdown counter
EXP_MIN, 2, minimum exposure time in ticks
EXP_MAX, 30, maximum exposure time in ticks (must be < 2**CNT_W)
EXP_DEFAULT, 16, exposure time after reset
TICK_DIV, 4, Clk cycles per exposure tick (>=1)
WAIT_LIMIT, 4, Clk cycles allowed for Expose to rise after Init

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Init  in  1  start-exposure request, level; rising edge used
Exp_increase  in  1  button; rising edge adds 1 tick
Exp_decrease  in  1  button; rising edge subtracts 1 tick
Expose  in  1  exposure-active flag from the sequencer
Ovf5  out  1  one-cycle pulse: exposure time elapsed
Exp_time  out  CNT_W  current programmed exposure time
Count  out  CNT_W  remaining ticks (0 when not counting)
Timer_busy  out  1  high in any state other than IDLE
Fault  out  1  one-cycle pulse on timeout or abort

Behaviour:
- Reset is asynchronous and active-high. While Reset is high: state=IDLE, Exp_time=EXP_DEFAULT, Count=0, prescaler=0, Ovf5=0, Fault=0, Timer_busy=0, edge-detect registers=0.
- All outputs are registered; all state updates occur on the Clk rising edge.
- Edge detection: Init, Exp_increase and Exp_decrease are each registered once. A rising edge is defined as in=1 while prev=0. Level-high inputs never repeat an action.
- Exposure adjust applies in IDLE only. Edges arriving in other states are discarded, not queued.
  - Increase: Exp_time+1, saturating at EXP_MAX.
  - Decrease: Exp_time-1, saturating at EXP_MIN.
  - Both edges in the same cycle: no change.
  - Exp_time updates the cycle after the edge is detected.
- States: IDLE, WAIT_EXP, COUNT, DONE.
- IDLE:
  - Init rising edge -> WAIT_EXP. Count loads Exp_time and the wait counter clears.
  - An adjust edge in the same cycle as the Init edge is ignored; the pre-edge Exp_time is loaded.
- WAIT_EXP:
  - Expose=1 -> COUNT; the prescaler clears.
  - If Expose stays 0 for WAIT_LIMIT consecutive cycles -> IDLE. Fault pulses for 1 cycle and Count=0.
- COUNT:
  - The prescaler increments each cycle. When it reaches TICK_DIV-1 it wraps to 0 and Count decrements.
  - Let c0 be the first cycle in COUNT. The decrement taking Count from 1 to 0 moves the state to DONE, with Ovf5=1 in cycle c0+Exp_time*TICK_DIV, for exactly one cycle.
  - Expose falls before expiry (abort) -> IDLE. Fault pulses, Count=0, and no Ovf5 is issued.
- DONE:
  - Ovf5 is high only in the entry cycle.
  - Stay in DONE while Expose=1. Expose=0 -> IDLE.
  - Init edges in DONE are ignored.
- Timer_busy = (state != IDLE).
- Count is 0 in IDLE and DONE.
- Reset asserted mid-operation aborts immediately. Ovf5 and Fault are never issued as a result of reset.
- Arithmetic is unsigned CNT_W bits. Saturation prevents wrap-around of Exp_time. Count never underflows because the decrement from 1 exits COUNT.

Test Plan:
- Reset, then 20 Exp_increase pulses (each 3 cycles high, 3 low) -> Exp_time goes 16..30 and then holds at 30; a held-high button gives exactly one step.
- Exp_time=2, then 3 Exp_decrease edges -> stays 2; increase and decrease edges in the same cycle -> Exp_time unchanged.
- Exp_time=16, TICK_DIV=4, Init edge, Expose raised 2 cycles later -> Ovf5 high for exactly 1 cycle, 64 cycles after COUNT entry; Count steps 16->0; Timer_busy stays high until Expose falls.
- Init edge with Expose held 0 -> Fault pulse after 4 cycles, return to IDLE, no Ovf5.
- Expose dropped at tick 5 of 16 -> Fault pulse, IDLE, Count=0, no Ovf5. Exp_increase edges during COUNT -> Exp_time unchanged afterwards.
- Reset asserted mid-COUNT (Count=9) -> all outputs at reset values immediately, Exp_time=16. A new Init after reset runs a full 16-tick exposure.

Source files
------------

// File: rtl/exposure_timer_ctrl.sv
// rtl/exposure_timer_ctrl.sv - programmable exposure-time controller for the exposure/readout sequencer
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Init         in   start-exposure request (level, rising edge acts)
//   Exp_increase in   button, rising edge adds one tick (IDLE only)
//   Exp_decrease in   button, rising edge removes one tick (IDLE only)
//   Expose       in   exposure-active flag from the sequencer
//   Ovf5         out  one-cycle pulse when the exposure time has elapsed
//   Exp_time     out  programmed exposure time in ticks
//   Count        out  remaining ticks, 0 when not counting
//   Timer_busy   out  high whenever the FSM is not in IDLE
//   Fault        out  one-cycle pulse on start timeout or exposure abort
module exposure_timer_ctrl #(
  parameter int CNT_W       = 5,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 16,
  parameter int TICK_DIV    = 4,
  parameter int WAIT_LIMIT  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Expose,
  output logic             Ovf5,
  output logic [CNT_W-1:0] Exp_time,
  output logic [CNT_W-1:0] Count,
  output logic             Timer_busy,
  output logic             Fault
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EXP,
    S_COUNT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PS_W-1:0]   presc, presc_nxt;
  logic [WT_W-1:0]   wait_cnt, wait_nxt;
  logic [CNT_W-1:0]  count_nxt, exp_nxt;
  logic              ovf_nxt, fault_nxt;
  logic              init_prev, inc_prev, dec_prev;
  logic              init_edge, inc_edge, dec_edge;

  // Edges are taken against last cycle's level, so a held button acts once.
  assign init_edge = Init & ~init_prev;
  assign inc_edge  = Exp_increase & ~inc_prev;
  assign dec_edge  = Exp_decrease & ~dec_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      presc      <= '0;
      wait_cnt   <= '0;
      Count      <= '0;
      Exp_time   <= CNT_W'(EXP_DEFAULT);
      Ovf5       <= 1'b0;
      Fault      <= 1'b0;
      Timer_busy <= 1'b0;
      init_prev  <= 1'b0;
      inc_prev   <= 1'b0;
      dec_prev   <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      wait_cnt   <= wait_nxt;
      Count      <= count_nxt;
      Exp_time   <= exp_nxt;
      Ovf5       <= ovf_nxt;
      Fault      <= fault_nxt;
      Timer_busy <= (state_nxt != S_IDLE);
      init_prev  <= Init;
      inc_prev   <= Exp_increase;
      dec_prev   <= Exp_decrease;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    wait_nxt  = wait_cnt;
    count_nxt = Count;
    exp_nxt   = Exp_time;
    ovf_nxt   = 1'b0;
    fault_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        count_nxt = '0;
        // Init wins over a simultaneous adjust so the pre-edge time is loaded.
        if (init_edge) begin
          state_nxt = S_WAIT_EXP;
          count_nxt = Exp_time;
          wait_nxt  = '0;
        end else if (inc_edge && !dec_edge) begin
          if (Exp_time < CNT_W'(EXP_MAX)) exp_nxt = Exp_time + CNT_W'(1);
        end else if (dec_edge && !inc_edge) begin
          if (Exp_time > CNT_W'(EXP_MIN)) exp_nxt = Exp_time - CNT_W'(1);
        end
      end

      S_WAIT_EXP: begin
        if (Expose) begin
          state_nxt = S_COUNT;
          presc_nxt = '0;
        end else if (wait_cnt == WT_W'(WAIT_LIMIT - 1)) begin
          state_nxt = S_IDLE;
          fault_nxt = 1'b1;
          count_nxt = '0;
        end else begin
          wait_nxt = wait_cnt + WT_W'(1);
        end
      end

      S_COUNT: begin
        // Abort is checked first: losing Expose on the final prescaler cycle
        // is still an abort, since expiry has not yet been reached.
        if (!Expose) begin
          state_nxt = S_IDLE;
          fault_nxt = 1'b1;
          count_nxt = '0;
        end else if (presc == PS_W'(TICK_DIV - 1)) begin
          presc_nxt = '0;
          if (Count == CNT_W'(1)) begin
            state_nxt = S_DONE;
            ovf_nxt   = 1'b1;
            count_nxt = '0;
          end else begin
            count_nxt = Count - CNT_W'(1);
          end
        end else begin
          presc_nxt = presc + PS_W'(1);
        end
      end

      S_DONE: begin
        count_nxt = '0;
        if (!Expose) state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// tb/tb_exposure_timer_ctrl.sv - directed self-checking bench for exposure_timer_ctrl
module tb_exposure_timer_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Init = 1'b0;
  logic       Exp_increase = 1'b0;
  logic       Exp_decrease = 1'b0;
  logic       Expose = 1'b0;
  logic       Ovf5;
  logic [4:0] Exp_time;
  logic [4:0] Count;
  logic       Timer_busy;
  logic       Fault;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  exposure_timer_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Init         (Init),
    .Exp_increase (Exp_increase),
    .Exp_decrease (Exp_decrease),
    .Expose       (Expose),
    .Ovf5         (Ovf5),
    .Exp_time     (Exp_time),
    .Count        (Count),
    .Timer_busy   (Timer_busy),
    .Fault        (Fault)
  );

  task automatic check(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse(input bit inc, input bit dec, input int hi, input int lo);
    Exp_increase = inc;
    Exp_decrease = dec;
    step(hi);
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    step(lo);
  endtask

  int ovf_at, ovf_pulses, busy_drop, fault_at, fault_pulses;
  int exp_val;

  initial begin
    // Reset values
    step(2);
    check("rst_exp_time", Exp_time, 16);
    check("rst_count", Count, 0);
    check("rst_busy", Timer_busy, 0);
    check("rst_ovf5", Ovf5, 0);
    check("rst_fault", Fault, 0);
    Reset = 1'b0;
    step(2);

    // Increase to saturation
    exp_val = 16;
    for (int i = 0; i < 20; i++) begin
      pulse(1'b1, 1'b0, 3, 3);
      if (exp_val < 30) exp_val++;
      check($sformatf("inc_%0d", i), Exp_time, exp_val);
    end

    // A button held high for many cycles steps only once
    pulse(1'b0, 1'b1, 10, 2);
    check("held_dec_one_step", Exp_time, 29);

    // Down to the minimum, then saturation at EXP_MIN
    for (int i = 0; i < 27; i++) pulse(1'b0, 1'b1, 1, 1);
    check("dec_to_min", Exp_time, 2);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1, 1);
    check("dec_sat_min", Exp_time, 2);
    pulse(1'b1, 1'b0, 1, 1);
    check("inc_from_min", Exp_time, 3);
    pulse(1'b1, 1'b1, 1, 1);
    check("inc_dec_same_cycle", Exp_time, 3);
    for (int i = 0; i < 13; i++) pulse(1'b1, 1'b0, 1, 1);
    check("back_to_16", Exp_time, 16);

    // Full exposure: Expose raised 2 cycles after the Init edge
    Init = 1'b1;
    step(1);
    check("init_busy", Timer_busy, 1);
    check("init_count_load", Count, 16);
    step(1);
    Expose = 1'b1;
    step(1);                        // first cycle in COUNT
    ovf_at = -1; ovf_pulses = 0; busy_drop = 0;
    for (int k = 0; k < 70; k++) begin
      if (k == 0)  check("cnt_c0", Count, 16);
      if (k == 4)  check("cnt_c4", Count, 15);
      if (k == 60) check("cnt_c60", Count, 1);
      if (k == 64) check("cnt_c64", Count, 0);
      if (Ovf5) begin ovf_pulses++; ovf_at = k; end
      if (!Timer_busy) busy_drop++;
      if (k == 66) Init = 1'b0;
      if (k == 67) Init = 1'b1;    // Init edge while in DONE is ignored
      step(1);
    end
    check("ovf_pulses", ovf_pulses, 1);
    check("ovf_cycle", ovf_at, 64);
    check("busy_held", busy_drop, 0);
    check("done_count", Count, 0);
    Expose = 1'b0;
    step(1);
    check("done_to_idle", Timer_busy, 0);
    step(3);
    check("done_init_ignored", Timer_busy, 0);
    Init = 1'b0;
    step(2);

    // Start timeout: Expose never rises
    Init = 1'b1;
    fault_at = -1; fault_pulses = 0; ovf_pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (Fault) begin fault_pulses++; fault_at = k; end
      if (Ovf5) ovf_pulses++;
    end
    check("timeout_fault_cycle", fault_at, 5);
    check("timeout_fault_pulses", fault_pulses, 1);
    check("timeout_no_ovf", ovf_pulses, 0);
    check("timeout_idle", Timer_busy, 0);
    check("timeout_count", Count, 0);
    Init = 1'b0;
    step(2);

    // Abort at tick 5 of 16, with an increase press during COUNT
    Init = 1'b1;
    Expose = 1'b1;
    step(2);                        // first cycle in COUNT
    check("abort_c0_count", Count, 16);
    Exp_increase = 1'b1;
    step(1);
    Exp_increase = 1'b0;
    step(19);
    check("abort_pre_count", Count, 11);
    Expose = 1'b0;
    step(1);
    check("abort_fault", Fault, 1);
    check("abort_count", Count, 0);
    check("abort_idle", Timer_busy, 0);
    check("abort_ovf", Ovf5, 0);
    ovf_pulses = 0;
    fault_pulses = 0;
    for (int k = 0; k < 70; k++) begin
      step(1);
      if (Ovf5) ovf_pulses++;
      if (Fault) fault_pulses++;
    end
    check("abort_no_late_ovf", ovf_pulses, 0);
    check("abort_single_fault", fault_pulses, 0);
    check("abort_exp_unchanged", Exp_time, 16);
    Init = 1'b0;
    step(2);

    // Reset asserted mid-COUNT
    pulse(1'b1, 1'b0, 1, 1);       // Exp_time 17 so reset has something to restore
    check("pre_reset_exp", Exp_time, 17);
    Init = 1'b1;
    Expose = 1'b1;
    step(2);
    step(32);
    check("pre_reset_count", Count, 9);
    #2;
    Reset = 1'b1;
    #1;
    check("reset_count", Count, 0);
    check("reset_busy", Timer_busy, 0);
    check("reset_exp", Exp_time, 16);
    check("reset_ovf", Ovf5, 0);
    check("reset_fault", Fault, 0);
    Init = 1'b0;
    Expose = 1'b0;
    step(2);
    Reset = 1'b0;
    fault_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (Fault || Ovf5) fault_pulses++;
    end
    check("post_reset_quiet", fault_pulses, 0);

    // A fresh exposure after reset runs the full 16 ticks
    Init = 1'b1;
    Expose = 1'b1;
    step(2);
    ovf_at = -1; ovf_pulses = 0;
    for (int k = 0; k < 70; k++) begin
      if (Ovf5) begin ovf_pulses++; ovf_at = k; end
      step(1);
    end
    check("post_reset_ovf_cycle", ovf_at, 64);
    check("post_reset_ovf_pulses", ovf_pulses, 1);
    Expose = 1'b0;
    Init = 1'b0;
    step(2);
    check("final_idle", Timer_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
